bcd_countdown_timer: RTL and testbench

- Parametrised HH:MM:SS BCD countdown timer, successor to the fixed 59:59:59 timer.
- Adds:
  - a runtime-loadable start value with BCD validation;
  - a clock prescaler so one count equals TICK_DIV clocks;
  - start/stop control;
  - one-shot and auto-reload modes;
  - a done pulse and a sticky expired flag.
- Sits between the system tick domain and the six-digit seven-segment display driver; digit outputs feed the display decoders directly.

---
 rtl/bcd_countdown_timer.sv | 134 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// HH:MM:SS BCD countdown timer with prescaler, start/stop, one-shot/auto-reload,
// validated runtime load, done pulse and sticky expired flag.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV    = 1,
  parameter logic [23:0] DEFAULT_VAL = 24'h595959
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        start,
  input  logic        stop,
  input  logic        reload_mode,
  output logic [3:0]  x5,
  output logic [3:0]  x4,
  output logic [3:0]  x3,
  output logic [3:0]  x2,
  output logic [3:0]  x1,
  output logic [3:0]  x0,
  output logic        running,
  output logic        done,
  output logic        expired,
  output logic        load_err
);

  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [23:0]   r_count;
  logic [23:0]   r_reload;
  logic [PW-1:0] r_presc;
  logic          r_running;
  logic          r_done;
  logic          r_expired;
  logic          r_load_err;

  logic [23:0]   w_dec;
  logic          w_borrow;
  logic          w_zero;
  logic          w_dec_zero;
  logic          w_tick;
  logic          w_load_valid;
  logic          w_load_ok;
  logic          w_start_ok;

  // Tens-of-minutes and tens-of-seconds digits are limited to 0..5.
  function automatic logic bcd_ok(input logic [23:0] v);
    return (v[23:20] <= 4'd9) && (v[19:16] <= 4'd9) && (v[15:12] <= 4'd5) &&
           (v[11:8]  <= 4'd9) && (v[7:4]   <= 4'd5) && (v[3:0]   <= 4'd9);
  endfunction

  // One-count decrement with borrow rippling from seconds up to hours.
  always_comb begin
    w_dec    = r_count;
    w_borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (w_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  assign w_zero       = (r_count == 24'd0);
  assign w_dec_zero   = (w_dec == 24'd0);
  assign w_tick       = r_running && (r_presc == PRESC_MAX);
  assign w_load_valid = bcd_ok(load_val);
  assign w_load_ok    = load && w_load_valid;
  // At zero only an armed auto-reload may start; expiry needs a fresh load.
  assign w_start_ok   = !w_zero || (reload_mode && !r_expired);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= DEFAULT_VAL;
      r_reload   <= DEFAULT_VAL;
      r_presc    <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_expired  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_load_err <= load && !w_load_valid;
      if (w_load_ok) begin
        r_count   <= load_val;
        r_reload  <= load_val;
        r_presc   <= '0;
        r_expired <= 1'b0;
      end else if (stop) begin
        r_running <= 1'b0;
        r_presc   <= '0;
      end else if (!r_running) begin
        if (start && w_start_ok) begin
          r_running <= 1'b1;
        end
      end else if (w_tick) begin
        r_presc <= '0;
        if (!w_zero) begin
          r_count <= w_dec;
          if (w_dec_zero) begin
            r_done <= 1'b1;
            if (!reload_mode) begin
              r_running <= 1'b0;
              r_expired <= 1'b1;
            end
          end
        end else if (reload_mode && (r_reload != 24'd0)) begin
          r_count <= r_reload;
        end else begin
          r_running <= 1'b0;
          r_expired <= 1'b1;
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign x5       = r_count[23:20];
  assign x4       = r_count[19:16];
  assign x3       = r_count[15:12];
  assign x2       = r_count[11:8];
  assign x1       = r_count[7:4];
  assign x0       = r_count[3:0];
  assign running  = r_running;
  assign done     = r_done;
  assign expired  = r_expired;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (TICK_DIV=1 and 4) share stimulus;
// expected states are queued as stimulus is driven and checked after each edge.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] load_val;
  logic        start;
  logic        stop;
  logic        reload_mode;

  logic [3:0] a5, a4, a3, a2, a1, a0;
  logic       a_run, a_done, a_exp, a_lerr;
  logic [3:0] b5, b4, b3, b2, b1, b0;
  logic       b_run, b_done, b_exp, b_lerr;

  logic [27:0] obs1;
  logic [27:0] obs4;
  logic [27:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic        rs;
    logic        ld;
    logic        sa;
    logic        sp;
    logic [23:0] lv;
    logic [27:0] ex;
  } step_t;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.TICK_DIV(1), .DEFAULT_VAL(24'h595959)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .reload_mode(reload_mode),
    .x5(a5), .x4(a4), .x3(a3), .x2(a2), .x1(a1), .x0(a0),
    .running(a_run), .done(a_done), .expired(a_exp), .load_err(a_lerr)
  );

  bcd_countdown_timer #(.TICK_DIV(4), .DEFAULT_VAL(24'h595959)) u_dut4 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .reload_mode(reload_mode),
    .x5(b5), .x4(b4), .x3(b3), .x2(b2), .x1(b1), .x0(b0),
    .running(b_run), .done(b_done), .expired(b_exp), .load_err(b_lerr)
  );

  assign obs1 = {a5, a4, a3, a2, a1, a0, a_run, a_done, a_exp, a_lerr};
  assign obs4 = {b5, b4, b3, b2, b1, b0, b_run, b_done, b_exp, b_lerr};

  function automatic logic [27:0] ev(input logic [23:0] d, input int r, input int dn,
                                     input int ex, input int le);
    return {d, 1'(r), 1'(dn), 1'(ex), 1'(le)};
  endfunction

  function automatic step_t mk(input int rs, input int ld, input int sa, input int sp,
                               input logic [23:0] lv, input logic [27:0] ex);
    step_t s;
    s.rs = 1'(rs);
    s.ld = 1'(ld);
    s.sa = 1'(sa);
    s.sp = 1'(sp);
    s.lv = lv;
    s.ex = ex;
    return s;
  endfunction

  // Reference decrement through total seconds, independent of digit borrows.
  function automatic logic [23:0] dec(input logic [23:0] v);
    int t, h, m, s;
    t = (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
        (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
        int'(v[7:4]) * 10 + int'(v[3:0]) - 1;
    h = t / 3600;
    m = (t % 3600) / 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] e;
    rst = 1'b1;
    exp_q.push_back(ev(24'h595959, 0, 0, 0, 0));
    exp_q.push_back(ev(24'h595959, 0, 0, 0, 0));
    @(posedge clk); #1;
    idle_inputs();
    e = exp_q.pop_front(); n_tests++;
    if (obs1 !== e) begin n_fail++; $display("FAIL reset_div1: got %h expected %h", obs1, e); end
    e = exp_q.pop_front(); n_tests++;
    if (obs4 !== e) begin n_fail++; $display("FAIL reset_div4: got %h expected %h", obs4, e); end
  endtask

  task automatic test_count_default();
    logic [23:0] v;
    logic [27:0] e;
    v = 24'h595959;
    start = 1'b1;
    exp_q.push_back(ev(v, 1, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs1 !== e) begin n_fail++; $display("FAIL count_start: got %h expected %h", obs1, e); end
    for (int i = 1; i <= 60; i++) begin
      v = dec(v);
      exp_q.push_back(ev(v, 1, 0, 0, 0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs1 !== e) begin
        n_fail++; $display("FAIL count_default edge %0d: got %h expected %h", i, obs1, e);
      end
    end
    stop = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_oneshot();
    logic [23:0] v;
    logic [27:0] e;
    int r, dn, ex;
    rst = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    reload_mode = 1'b0;
    load = 1'b1; load_val = 24'h000003;
    exp_q.push_back(ev(24'h000003, 0, 0, 0, 0));
    @(posedge clk); #1;
    load = 1'b0; start = 1'b1;
    e = exp_q.pop_front(); n_tests++;
    if (obs4 !== e) begin n_fail++; $display("FAIL oneshot_load: got %h expected %h", obs4, e); end
    exp_q.push_back(ev(24'h000003, 1, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    e = exp_q.pop_front(); n_tests++;
    if (obs4 !== e) begin n_fail++; $display("FAIL oneshot_start: got %h expected %h", obs4, e); end
    v = 24'h000003; r = 1; ex = 0;
    for (int c = 1; c <= 14; c++) begin
      dn = 0;
      if (r == 1 && c % 4 == 0) begin
        v = dec(v);
        if (v == 24'd0) begin dn = 1; r = 0; ex = 1; end
      end
      exp_q.push_back(ev(v, r, dn, ex, 0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs4 !== e) begin
        n_fail++; $display("FAIL oneshot cycle %0d: got %h expected %h", c, obs4, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      start = (c == 0);
      exp_q.push_back(ev(24'h000000, 0, 0, 1, 0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs4 !== e) begin
        n_fail++; $display("FAIL oneshot_restart_ignored %0d: got %h expected %h", c, obs4, e);
      end
    end
    start = 1'b0;
    load = 1'b1; load_val = 24'h000002;
    exp_q.push_back(ev(24'h000002, 0, 0, 0, 0));
    @(posedge clk); #1;
    idle_inputs();
    e = exp_q.pop_front(); n_tests++;
    if (obs4 !== e) begin n_fail++; $display("FAIL oneshot_rearm: got %h expected %h", obs4, e); end
  endtask

  task automatic test_borrow();
    step_t s[$];
    logic [27:0] e;
    s.push_back(mk(1, 0, 0, 0, 24'h0,      ev(24'h595959, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 24'h100000, ev(24'h100000, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 0, 24'h0,      ev(24'h100000, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h095959, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h095958, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 1, 24'h0,      ev(24'h095958, 0, 0, 0, 0)));
    foreach (s[i]) begin
      rst = s[i].rs; load = s[i].ld; start = s[i].sa; stop = s[i].sp; load_val = s[i].lv;
      exp_q.push_back(s[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs1 !== e) begin n_fail++; $display("FAIL borrow step %0d: got %h expected %h", i, obs1, e); end
    end
    idle_inputs();
  endtask

  task automatic test_autoreload();
    step_t s[$];
    logic [27:0] e;
    reload_mode = 1'b1;
    s.push_back(mk(1, 0, 0, 0, 24'h0,      ev(24'h595959, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 24'h000002, ev(24'h000002, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 0, 24'h0,      ev(24'h000002, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000001, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000000, 1, 1, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000002, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000001, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000000, 1, 1, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000002, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000001, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 1, 24'h0,      ev(24'h000001, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000001, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000001, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 0, 24'h0,      ev(24'h000001, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000000, 1, 1, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000002, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 1, 24'h0,      ev(24'h000002, 0, 0, 0, 0)));
    foreach (s[i]) begin
      rst = s[i].rs; load = s[i].ld; start = s[i].sa; stop = s[i].sp; load_val = s[i].lv;
      exp_q.push_back(s[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs1 !== e) begin n_fail++; $display("FAIL autoreload step %0d: got %h expected %h", i, obs1, e); end
    end
    idle_inputs();
    reload_mode = 1'b0;
  endtask

  task automatic test_invalid_load();
    step_t s[$];
    logic [27:0] e;
    s.push_back(mk(1, 0, 0, 0, 24'h0,      ev(24'h595959, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 24'h000005, ev(24'h000005, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 0, 24'h0,      ev(24'h000005, 1, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 24'h006000, ev(24'h000004, 1, 0, 0, 1)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000003, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000002, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 1, 24'h0,      ev(24'h000002, 0, 0, 0, 0)));
    foreach (s[i]) begin
      rst = s[i].rs; load = s[i].ld; start = s[i].sa; stop = s[i].sp; load_val = s[i].lv;
      exp_q.push_back(s[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs1 !== e) begin n_fail++; $display("FAIL invalid_load step %0d: got %h expected %h", i, obs1, e); end
    end
    idle_inputs();
  endtask

  task automatic test_edge_cases();
    step_t s[$];
    logic [27:0] e;
    s.push_back(mk(1, 0, 0, 0, 24'h0,      ev(24'h595959, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 24'h000005, ev(24'h000005, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 0, 24'h0,      ev(24'h000005, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000004, 1, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 24'h000020, ev(24'h000020, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000019, 1, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 1, 24'h0,      ev(24'h000019, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 1, 24'h0,      ev(24'h000019, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h000019, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 24'h001234, ev(24'h001234, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 0, 24'h0,      ev(24'h001234, 1, 0, 0, 0)));
    s.push_back(mk(1, 1, 1, 0, 24'h000007, ev(24'h595959, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 24'h0,      ev(24'h595959, 0, 0, 0, 0)));
    foreach (s[i]) begin
      rst = s[i].rs; load = s[i].ld; start = s[i].sa; stop = s[i].sp; load_val = s[i].lv;
      exp_q.push_back(s[i].ex);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_tests++;
      if (obs1 !== e) begin n_fail++; $display("FAIL edge_case step %0d: got %h expected %h", i, obs1, e); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    reload_mode = 1'b0; load_val = 24'h0;
    test_reset();
    test_count_default();
    test_oneshot();
    test_borrow();
    test_autoreload();
    test_invalid_load();
    test_edge_cases();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
